button_debounce: RTL and testbench



---
 rtl/button_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/button_debounce.sv | 174 +++++++++++++++++
 tb/tb_button_debounce.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton conditioning path: FSM state encoding
// and time-to-cycle conversion helpers used to size the debounce counters.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Divide first so that large clock rates cannot overflow the product.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 32'd1000000) * us;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for one asynchronous input pin. RST_VAL sets the
// idle level both flops return to on reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: d is only trusted after the second flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchroniser, stable-count debounce FSM and
// registered press/release strobes. Long-press strobe: BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd25000000,
  parameter int unsigned DEBOUNCE_US = 32'd10000,
  parameter int unsigned ACTIVE_LOW  = 32'd0,
  parameter int unsigned LONG_MS     = 32'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned N     = us_to_cycles(CLK_HZ, DEBOUNCE_US);
  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic SYNC_IDLE = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;

  logic             sync_q_s;
  logic             s_s;
  btn_state_e       state_r;
  btn_state_e       state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic             level_r;
  logic             level_n;
  logic             press_r;
  logic             press_n;
  logic             release_r;
  logic             release_n;

  sync_2ff #(
    .RST_VAL (SYNC_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (sync_q_s)
  );

  assign s_s = (ACTIVE_LOW != 32'd0) ? ~sync_q_s : sync_q_s;

  // Debounce next-state: the first mismatching sample already counts as one,
  // so the level flips on the N-th consecutive mismatching sample.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    level_n   = level_r;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state_r)
      RELEASED: begin
        if (s_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_s) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n   = cnt_r + 1'b1;
        end
      end
      PRESSED: begin
        if (!s_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_n   = RELEASED;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n     = cnt_r + 1'b1;
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

  // Debounce state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RELEASED;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      level_r   <= level_n;
      press_r   <= press_n;
      release_r <= release_n;
    end
  end

  assign btn_level   = level_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned LONG_N = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int unsigned HCNT_W = $clog2(LONG_N + 32'd1);
  localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(LONG_N);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_N - 32'd1);

  logic [HCNT_W-1:0] hcnt_r;
  logic [HCNT_W-1:0] hcnt_n;
  logic              long_r;
  logic              long_n;

  // Hold timer: survives a bounce back to PRESSED, saturation gives one pulse per press.
  always_comb begin
    hcnt_n = hcnt_r;
    long_n = 1'b0;
    if ((state_r == PRESS_WAIT) && (state_n == PRESSED)) begin
      hcnt_n = '0;
    end else if ((state_r == RELEASE_WAIT) && (state_n == RELEASED)) begin
      hcnt_n = '0;
    end else if (((state_r == PRESSED) || (state_r == RELEASE_WAIT)) &&
                 (hcnt_r != HCNT_SAT)) begin
      hcnt_n = hcnt_r + 1'b1;
      long_n = (hcnt_r == HCNT_LAST);
    end else begin
      hcnt_n = hcnt_r;
    end
  end

  // Hold timer and long-press strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_r <= '0;
      long_r <= 1'b0;
    end else begin
      hcnt_r <= hcnt_n;
      long_r <= long_n;
    end
  end

  assign btn_long = long_r;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with N=10, LONG_N=1000; an active-high and
// an active-low instance see complementary pins and must behave identically.
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic raw;
  logic raw_al;
  logic lvl0, prs0, rel0, lng0;
  logic lvl1, prs1, rel1, lng1;
  logic [3:0] obs0;
  logic [3:0] obs1;
  logic [3:0] exp_v;
  int n_cmp;
  int n_err;

  assign raw_al = ~raw;
  assign obs0 = {lvl0, prs0, rel0, lng0};
  assign obs1 = {lvl1, prs1, rel1, lng1};

  button_debounce #(
    .CLK_HZ(32'd1000000), .DEBOUNCE_US(32'd10), .ACTIVE_LOW(32'd0), .LONG_MS(32'd1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_long(lng0)
  );

  button_debounce #(
    .CLK_HZ(32'd1000000), .DEBOUNCE_US(32'd10), .ACTIVE_LOW(32'd1), .LONG_MS(32'd1)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw_al),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .btn_long(lng1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    raw = 1'b0;
    tick();
    tick();
    exp_v = 4'b0000;
    n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL reset got=%b exp=%b", obs0, exp_v); end
    n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL reset_al got=%b exp=%b", obs1, exp_v); end
    rst = 1'b0;
    tick();
    n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL post_reset got=%b exp=%b", obs0, exp_v); end
    n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL post_reset_al got=%b exp=%b", obs1, exp_v); end
  endtask

  task automatic test_clean_press;
    raw = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp_v = {(k >= 12), (k == 12), 1'b0, 1'b0};
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL clean_press k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL clean_press_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
  endtask

  task automatic test_release;
    raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = {(k < 12), 1'b0, (k == 12), 1'b0};
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL release k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL release_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
  endtask

  task automatic test_glitch;
    exp_v = 4'b0000;
    for (int k = 1; k <= 29; k++) begin
      raw = (k <= 9) ? 1'b1 : 1'b0;
      tick();
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL glitch k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL glitch_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
  endtask

  task automatic test_bounce;
    exp_v = 4'b0000;
    for (int k = 0; k < 40; k++) begin
      raw = (((k / 3) % 2) == 0) ? 1'b1 : 1'b0;
      tick();
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL bounce k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL bounce_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
    raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = {(k >= 12), (k == 12), 1'b0, 1'b0};
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL bounce_settle k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL bounce_settle_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
  endtask

  task automatic test_reset_mid_wait;
    raw = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    exp_v = 4'b0000;
    n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL mid_wait_rst got=%b exp=%b", obs0, exp_v); end
    n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL mid_wait_rst_al got=%b exp=%b", obs1, exp_v); end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = {(k >= 12), (k == 12), 1'b0, 1'b0};
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL after_rst k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL after_rst_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
    // Asynchronous clear of a pressed level, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    exp_v = 4'b0000;
    n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL async_rst got=%b exp=%b", obs0, exp_v); end
    n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL async_rst_al got=%b exp=%b", obs1, exp_v); end
    raw = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_longpress;
    raw = 1'b1;
    for (int k = 1; k <= 1500; k++) begin
      tick();
      exp_v = {(k >= 12), (k == 12), 1'b0, (LP_EN && (k == 1012))};
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL long_hold k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL long_hold_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
    raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = {(k < 12), 1'b0, (k == 12), 1'b0};
      n_cmp++; if (obs0 !== exp_v) begin n_err++; $display("FAIL long_release k=%0d got=%b exp=%b", k, obs0, exp_v); end
      n_cmp++; if (obs1 !== exp_v) begin n_err++; $display("FAIL long_release_al k=%0d got=%b exp=%b", k, obs1, exp_v); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    raw = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_bounce();
    test_release();
    test_reset_mid_wait();
    test_longpress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
